// File: rtl/ceyloniac_mult_div.sv
`default_nettype none
// ============================================================================
// Module      : ceyloniac_mult_div
// Description : Iterative W-cycle shift-add multiplier / restoring divider
//               producing a HI/LO result pair behind a start/busy/done handshake.
//               Optional abort input enabled by CEYLONIAC_MD_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ceyloniac_mult_div #(
    parameter int RAM_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic [RAM_DATA_WIDTH-1:0] read_data_a,
    input  logic [RAM_DATA_WIDTH-1:0] read_data_b,
`ifdef CEYLONIAC_MD_ABORT_EN
    input  logic                      abort,
`endif
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero,
    output logic [RAM_DATA_WIDTH-1:0] hi,
    output logic [RAM_DATA_WIDTH-1:0] lo
);

    localparam int W  = RAM_DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    a_raw_q, a_raw_d;
    logic            is_div_q, is_div_d;
    logic            b_zero_q, b_zero_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            w_abort;
    logic            w_signed;
    logic [W-1:0]    w_a_mag;
    logic [W-1:0]    w_b_mag;
    logic [W:0]      w_mul_sum;
    logic [W:0]      w_div_shift;
    logic [W-1:0]    w_div_diff;
    logic            w_div_ge;
    logic [2*W-1:0]  w_acc_neg;
    logic [W-1:0]    w_quo;
    logic [W-1:0]    w_rem;
    logic [W-1:0]    w_quo_neg;
    logic [W-1:0]    w_rem_neg;

`ifdef CEYLONIAC_MD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // op[0] selects signed, op[1] selects divide
    assign w_signed = op[0];
    assign w_a_mag  = (w_signed && read_data_a[W-1]) ? -read_data_a : read_data_a;
    assign w_b_mag  = (w_signed && read_data_b[W-1]) ? -read_data_b : read_data_b;

    assign w_mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign w_div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    // When the subtract succeeds the true difference is below the divisor, so W bits suffice
    assign w_div_diff  = w_div_shift[W-1:0] - opnd_q;

    assign w_acc_neg = -acc_q;
    assign w_quo     = acc_q[W-1:0];
    assign w_rem     = acc_q[2*W-1:W];
    assign w_quo_neg = -w_quo;
    assign w_rem_neg = -w_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        is_div_d  = is_div_q;
        b_zero_d  = b_zero_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = {{W{1'b0}}, w_a_mag};
                    opnd_d    = w_b_mag;
                    a_raw_d   = read_data_a;
                    is_div_d  = op[1];
                    b_zero_d  = (read_data_b == '0);
                    neg_res_d = w_signed & (read_data_a[W-1] ^ read_data_b[W-1]);
                    neg_rem_d = w_signed & read_data_a[W-1];
                    cnt_d     = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (w_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = {(w_div_ge ? w_div_diff : w_div_shift[W-1:0]),
                                 acc_q[W-2:0], w_div_ge};
                    end else begin
                        acc_d = {w_mul_sum, acc_q[W-1:1]};
                    end
                    cnt_d = cnt_q + c_CNT_ONE;
                    if (cnt_q == c_CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (w_abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q && b_zero_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d  = neg_rem_q ? w_rem_neg : w_rem;
                        lo_d  = neg_res_q ? w_quo_neg : w_quo;
                        dbz_d = 1'b0;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? w_acc_neg : acc_q;
                        dbz_d        = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            is_div_q  <= 1'b0;
            b_zero_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            is_div_q  <= is_div_d;
            b_zero_q  <= b_zero_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire
